// File: rtl/trigger_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : trigger_sequencer_if
// Purpose  : Configuration write bus, sample input stream, sample output
//            stream and status signals of the trigger sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface trigger_sequencer_if #(
  parameter int BAW = 8,
  parameter int BDW = 32,
  parameter int SDW = 32,
  parameter int TLN = 4
);
  localparam int LLW = $clog2(TLN);

  // configuration write bus
  logic           bus_wvalid;
  logic [BAW-1:0] bus_waddr;
  logic [BDW-1:0] bus_wdata;
  logic           bus_wready;

  // sample input stream
  logic           sti_tvalid;
  logic [SDW-1:0] sti_tdata;
  logic           sti_tready;

  // sample output stream
  logic           sto_tvalid;
  logic [SDW-1:0] sto_tdata;
  logic           sto_ttrig;
  logic           sto_tready;

  // status
  logic [1:0]     sts_state;
  logic [LLW-1:0] sts_level;

  modport master (
    output bus_wvalid, bus_waddr, bus_wdata,
    input  bus_wready,
    output sti_tvalid, sti_tdata,
    input  sti_tready,
    output sto_tready,
    input  sto_tvalid, sto_tdata, sto_ttrig,
    input  sts_state, sts_level
  );

  modport slave (
    input  bus_wvalid, bus_waddr, bus_wdata,
    output bus_wready,
    input  sti_tvalid, sti_tdata,
    output sti_tready,
    input  sto_tready,
    output sto_tvalid, sto_tdata, sto_ttrig,
    output sts_state, sts_level
  );
endinterface
`default_nettype wire

// File: rtl/trigger_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : trigger_sequencer
// Purpose  : Multi-level pattern trigger on a sample stream. Matchers compare
//            masked sample bits, levels combine matchers (AND/OR) and count
//            occurrences; the last level fires, tags the sample and runs an
//            optional post-trigger count.
// Revision : 1.0 - initial release
// ============================================================================
module trigger_sequencer #(
  parameter int BAW = 8,
  parameter int BDW = 32,
  parameter int SDW = 32,
  parameter int TMN = 4,
  parameter int TLN = 4,
  parameter int TCW = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  trigger_sequencer_if.slave bus
);
  localparam int LLW = $clog2(TLN);
  localparam logic [BAW-1:0] c_ADDR_CTRL  = '0;
  localparam logic [BAW-1:0] c_ADDR_POST  = BAW'(1);
  localparam int             c_MATCH_BASE = 16;
  localparam int             c_LEVEL_BASE = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_POST  = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [LLW-1:0] r_lvl, w_lvl_nxt;
  logic [TCW-1:0] r_cnt, w_cnt_nxt;
  logic [TCW-1:0] r_postcnt, w_post_nxt;
  logic           w_fire;

  // configuration registers
  logic [SDW-1:0] r_mask  [TMN];
  logic [SDW-1:0] r_value [TMN];
  logic [TMN-1:0] r_lsel  [TLN];
  logic [TCW-1:0] r_ltgt  [TLN];
  logic [TLN-1:0] r_lmode;
  logic [TLN-1:0] r_llast;
  logic [TCW-1:0] r_post_cfg;

  // output stream register
  logic           r_sto_tvalid;
  logic [SDW-1:0] r_sto_tdata;
  logic           r_sto_ttrig;

  logic           w_ctrl_wr, w_arm, w_abort, w_cfg_wr, w_xfer, w_sti_tready;
  logic [TMN-1:0] w_mhit, w_sel;
  logic           w_hit_and, w_hit_or, w_lvl_hit;
  logic [TCW:0]   w_cnt_inc;
  logic [TCW-1:0] w_tgt_eff;
  logic           w_unused;

  assign w_ctrl_wr    = bus.bus_wvalid && (bus.bus_waddr == c_ADDR_CTRL);
  assign w_arm        = w_ctrl_wr && bus.bus_wdata[0];
  assign w_abort      = w_ctrl_wr && bus.bus_wdata[1];
  // configuration is frozen while a sequence is running
  assign w_cfg_wr     = bus.bus_wvalid && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_sti_tready = bus.sto_tready || !r_sto_tvalid;
  assign w_xfer       = bus.sti_tvalid && w_sti_tready;
  assign w_unused     = ^bus.bus_wdata;

  // matchers evaluate the incoming sample combinationally
  for (genvar m = 0; m < TMN; m++) begin : g_match
    assign w_mhit[m] = ((bus.sti_tdata ^ r_value[m]) & r_mask[m]) == '0;
  end

  // AND of an empty selection is true, OR of an empty selection is false
  assign w_sel     = r_lsel[r_lvl];
  assign w_hit_and = &(~w_sel | w_mhit);
  assign w_hit_or  = |(w_sel & w_mhit);
  assign w_lvl_hit = r_lmode[r_lvl] ? w_hit_or : w_hit_and;

  assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;
  assign w_tgt_eff = (r_ltgt[r_lvl] == '0) ? TCW'(1) : r_ltgt[r_lvl];

  // configuration register writes by address decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_post_cfg <= '0;
      r_lmode    <= '0;
      r_llast    <= '0;
      for (int m = 0; m < TMN; m++) begin
        r_mask[m]  <= '0;
        r_value[m] <= '0;
      end
      for (int l = 0; l < TLN; l++) begin
        r_lsel[l] <= '0;
        r_ltgt[l] <= '0;
      end
    end else if (w_cfg_wr) begin
      if (bus.bus_waddr == c_ADDR_POST) r_post_cfg <= bus.bus_wdata[TCW-1:0];
      for (int m = 0; m < TMN; m++) begin
        if (bus.bus_waddr == BAW'(c_MATCH_BASE + 2*m))     r_mask[m]  <= bus.bus_wdata[SDW-1:0];
        if (bus.bus_waddr == BAW'(c_MATCH_BASE + 2*m + 1)) r_value[m] <= bus.bus_wdata[SDW-1:0];
      end
      for (int l = 0; l < TLN; l++) begin
        if (bus.bus_waddr == BAW'(c_LEVEL_BASE + 2*l)) begin
          r_lsel[l]  <= bus.bus_wdata[TMN-1:0];
          r_lmode[l] <= bus.bus_wdata[8];
          r_llast[l] <= bus.bus_wdata[9];
        end
        if (bus.bus_waddr == BAW'(c_LEVEL_BASE + 2*l + 1)) r_ltgt[l] <= bus.bus_wdata[TCW-1:0];
      end
    end
  end

  // sequencer state, level and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_lvl     <= '0;
      r_cnt     <= '0;
      r_postcnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lvl     <= w_lvl_nxt;
      r_cnt     <= w_cnt_nxt;
      r_postcnt <= w_post_nxt;
    end
  end

  // next state: abort beats arm, arm beats sample evaluation
  always_comb begin
    w_state_nxt = r_state;
    w_lvl_nxt   = r_lvl;
    w_cnt_nxt   = r_cnt;
    w_post_nxt  = r_postcnt;
    w_fire      = 1'b0;
    if (w_abort) begin
      w_state_nxt = ST_IDLE;
      w_lvl_nxt   = '0;
      w_cnt_nxt   = '0;
      w_post_nxt  = '0;
    end else if (w_arm) begin
      w_state_nxt = ST_ARMED;
      w_lvl_nxt   = '0;
      w_cnt_nxt   = '0;
      w_post_nxt  = '0;
    end else if (w_xfer) begin
      case (r_state)
        ST_ARMED: begin
          if (w_lvl_hit) begin
            if (w_cnt_inc >= {1'b0, w_tgt_eff}) begin
              w_cnt_nxt = '0;
              if (r_llast[r_lvl] || (r_lvl == LLW'(TLN-1))) begin
                w_fire = 1'b1;
                if (r_post_cfg == '0) begin
                  w_state_nxt = ST_DONE;
                end else begin
                  w_state_nxt = ST_POST;
                  w_post_nxt  = r_post_cfg;
                end
              end else begin
                w_lvl_nxt = r_lvl + 1'b1;
              end
            end else begin
              w_cnt_nxt = w_cnt_inc[TCW-1:0];
            end
          end
        end
        ST_POST: begin
          w_post_nxt = r_postcnt - 1'b1;
          if (r_postcnt <= TCW'(1)) w_state_nxt = ST_DONE;
        end
        default: ;
      endcase
    end
  end

  // single-stage output register; samples pass through in every state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sto_tvalid <= 1'b0;
      r_sto_tdata  <= '0;
      r_sto_ttrig  <= 1'b0;
    end else if (w_xfer) begin
      r_sto_tvalid <= 1'b1;
      r_sto_tdata  <= bus.sti_tdata;
      r_sto_ttrig  <= w_fire;
    end else if (bus.sto_tready) begin
      r_sto_tvalid <= 1'b0;
      r_sto_ttrig  <= 1'b0;
    end
  end

  assign bus.bus_wready = 1'b1;
  assign bus.sti_tready = w_sti_tready;
  assign bus.sto_tvalid = r_sto_tvalid;
  assign bus.sto_tdata  = r_sto_tdata;
  assign bus.sto_ttrig  = r_sto_ttrig;
  assign bus.sts_state  = r_state;
  assign bus.sts_level  = r_lvl;
endmodule
`default_nettype wire

// File: tb/tb_trigger_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_trigger_sequencer
// Purpose  : Directed scenarios plus randomized traffic for trigger_sequencer,
//            checked cycle by cycle against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trigger_sequencer;
  localparam int BAW = 8, BDW = 32, SDW = 32, TMN = 4, TLN = 4, TCW = 16;
  localparam int IDLE = 0, ARMED = 1, POST = 2, DONE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  trigger_sequencer_if #(.BAW(BAW), .BDW(BDW), .SDW(SDW), .TLN(TLN)) u_if ();

  trigger_sequencer #(
    .BAW(BAW), .BDW(BDW), .SDW(SDW), .TMN(TMN), .TLN(TLN), .TCW(TCW)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if)
  );

  always #5 clk = ~clk;

  // reference model: configuration, sequence position, expected output queue
  logic [31:0] m_mask [TMN];
  logic [31:0] m_val  [TMN];
  logic [3:0]  m_sel  [TLN];
  bit          m_or   [TLN];
  bit          m_last [TLN];
  int          m_tgt  [TLN];
  int          m_postcfg, m_state, m_lvl, m_cnt, m_post;
  typedef struct { logic [31:0] d; bit t; } item_t;
  item_t q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < TMN; i++) begin m_mask[i] = 0; m_val[i] = 0; end
    for (int i = 0; i < TLN; i++) begin m_sel[i] = 0; m_or[i] = 0; m_last[i] = 0; m_tgt[i] = 0; end
    m_postcfg = 0; m_state = IDLE; m_lvl = 0; m_cnt = 0; m_post = 0;
    q.delete();
  endfunction

  function automatic bit level_hit(input logic [31:0] d);
    int n_sel = 0, n_hit = 0;
    for (int m = 0; m < TMN; m++) begin
      if (m_sel[m_lvl][m]) begin
        n_sel++;
        if (((d ^ m_val[m]) & m_mask[m]) == 32'd0) n_hit++;
      end
    end
    return m_or[m_lvl] ? (n_hit > 0) : (n_hit == n_sel);
  endfunction

  function automatic void apply_cfg(input int a, input logic [31:0] wd);
    if (a == 1) m_postcfg = int'(wd[15:0]);
    if (a >= 16 && a < 16 + 2*TMN) begin
      if (a % 2 == 0) m_mask[(a-16)/2] = wd; else m_val[(a-16)/2] = wd;
    end
    if (a >= 32 && a < 32 + 2*TLN) begin
      if (a % 2 == 0) begin
        m_sel[(a-32)/2] = wd[3:0]; m_or[(a-32)/2] = wd[8]; m_last[(a-32)/2] = wd[9];
      end else m_tgt[(a-32)/2] = int'(wd[15:0]);
    end
  endfunction

  // one cycle of model behaviour; returns whether this sample fires
  function automatic bit model_step(input bit wr, input int a, input logic [31:0] wd,
                                    input bit xfer, input logic [31:0] d);
    bit fire = 0;
    bit cfg_ok = (m_state == IDLE) || (m_state == DONE);
    if (wr && a == 0 && wd[1]) begin
      m_state = IDLE; m_lvl = 0; m_cnt = 0; m_post = 0;
    end else if (wr && a == 0 && wd[0]) begin
      m_state = ARMED; m_lvl = 0; m_cnt = 0; m_post = 0;
    end else if (xfer && m_state == ARMED) begin
      if (level_hit(d)) begin
        m_cnt++;
        if (m_cnt >= ((m_tgt[m_lvl] == 0) ? 1 : m_tgt[m_lvl])) begin
          m_cnt = 0;
          if (m_last[m_lvl] || m_lvl == TLN-1) begin
            fire = 1;
            if (m_postcfg == 0) m_state = DONE;
            else begin m_state = POST; m_post = m_postcfg; end
          end else m_lvl++;
        end
      end
    end else if (xfer && m_state == POST) begin
      m_post--;
      if (m_post == 0) m_state = DONE;
    end
    if (wr && a != 0 && cfg_ok) apply_cfg(a, wd);
    return fire;
  endfunction

  // check outputs mid-cycle, advance the model, then move to the next negedge
  task automatic tick();
    bit rdy, xfer, cons, fire;
    #1;
    if (q.size() > 0) begin
      check("sto_tvalid", u_if.sto_tvalid, 1);
      check("sto_tdata", u_if.sto_tdata, q[0].d);
      check("sto_ttrig", u_if.sto_ttrig, q[0].t);
    end else begin
      check("sto_tvalid", u_if.sto_tvalid, 0);
      check("sto_ttrig", u_if.sto_ttrig, 0);
    end
    check("sts_state", u_if.sts_state, m_state);
    check("sts_level", u_if.sts_level, m_lvl);
    check("bus_wready", u_if.bus_wready, 1);
    rdy  = u_if.sto_tready || (q.size() == 0);
    check("sti_tready", u_if.sti_tready, rdy);
    xfer = u_if.sti_tvalid && rdy;
    cons = u_if.sto_tready && (q.size() > 0);
    fire = model_step(u_if.bus_wvalid, int'(u_if.bus_waddr), u_if.bus_wdata, xfer, u_if.sti_tdata);
    if (cons) void'(q.pop_front());
    if (xfer) q.push_back('{u_if.sti_tdata, fire});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_wr(input int a, input logic [31:0] d);
    u_if.bus_wvalid = 1'b1;
    u_if.bus_waddr  = BAW'(a);
    u_if.bus_wdata  = d;
    tick();
    u_if.bus_wvalid = 1'b0;
  endtask

  task automatic send(input logic [31:0] d);
    u_if.sti_tvalid = 1'b1;
    u_if.sti_tdata  = d;
    tick();
    u_if.sti_tvalid = 1'b0;
  endtask

  function automatic logic [31:0] rnd_mask();
    case ($urandom % 4)
      0: return 32'h0;
      1: return 32'hF;
      2: return 32'h3;
      default: return 32'hC;
    endcase
  endfunction

  function automatic int rnd_addr();
    case ($urandom % 5)
      0: return 1;
      1: return 16 + int'($urandom % 8);
      2: return 32 + int'($urandom % 8);
      3: return 48 + int'($urandom % 4);
      default: return 2;
    endcase
  endfunction

  initial begin
    u_if.bus_wvalid = 0; u_if.bus_waddr = '0; u_if.bus_wdata = '0;
    u_if.sti_tvalid = 0; u_if.sti_tdata = '0; u_if.sto_tready = 1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_state", u_if.sts_state, 0);
    check("rst_tvalid", u_if.sto_tvalid, 0);
    check("rst_tdata", u_if.sto_tdata, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // single level, value 5 on matcher 0, no post count
    bus_wr(16, 32'hF); bus_wr(17, 32'h5); bus_wr(32, 32'h201); bus_wr(33, 1); bus_wr(1, 0);
    bus_wr(0, 1);
    send(3); send(5); send(5); tick();
    check("s030_done", u_if.sts_state, DONE);

    // two levels: three A's then a B
    bus_wr(0, 2);
    bus_wr(16, 32'hF); bus_wr(17, 32'hA); bus_wr(18, 32'hF); bus_wr(19, 32'hB);
    bus_wr(32, 32'h001); bus_wr(33, 3); bus_wr(34, 32'h202); bus_wr(35, 1);
    bus_wr(0, 1);
    send(32'hA); send(32'hB); send(32'hA);
    check("s031_lvl0", u_if.sts_level, 0);
    send(32'hA);
    check("s031_lvl1", u_if.sts_level, 1);
    send(32'hB); tick();
    check("s031_done", u_if.sts_state, DONE);

    // post count 4 with a stalled consumer in the middle
    bus_wr(17, 32'h5); bus_wr(32, 32'h201); bus_wr(33, 1); bus_wr(1, 4);
    bus_wr(0, 1);
    send(5); send(1);
    u_if.sto_tready = 0; u_if.sti_tvalid = 1; u_if.sti_tdata = 32'h77;
    repeat (5) tick();
    check("s032_post", u_if.sts_state, POST);
    u_if.sto_tready = 1;
    tick();
    send(2); send(3); tick();
    check("s032_done", u_if.sts_state, DONE);

    // empty selections: OR never hits, AND always hits
    bus_wr(1, 0); bus_wr(32, 32'h100); bus_wr(33, 1);
    bus_wr(0, 1);
    for (int i = 0; i < 6; i++) send($urandom);
    check("s033_or_armed", u_if.sts_state, ARMED);
    bus_wr(0, 2);
    bus_wr(32, 32'h200); bus_wr(33, 2);
    bus_wr(0, 1);
    send(32'h1234);
    check("s033_and_armed", u_if.sts_state, ARMED);
    send(32'h9);
    check("s033_and_done", u_if.sts_state, DONE);

    // arm+abort together, frozen config while armed
    bus_wr(16, 32'hF); bus_wr(17, 32'h5); bus_wr(32, 32'h201); bus_wr(33, 1);
    bus_wr(0, 1);
    bus_wr(16, 32'h0);
    bus_wr(0, 3);
    check("s034_idle", u_if.sts_state, IDLE);
    bus_wr(0, 1);
    send(3); send(3);
    check("s034_mask_kept", u_if.sts_state, ARMED);

    // asynchronous reset during POST
    bus_wr(0, 2); bus_wr(1, 6); bus_wr(0, 1);
    send(5); send(6);
    check("s035_post", u_if.sts_state, POST);
    rst = 1'b1;
    #1;
    check("s035_state", u_if.sts_state, 0);
    check("s035_level", u_if.sts_level, 0);
    check("s035_tvalid", u_if.sto_tvalid, 0);
    check("s035_ttrig", u_if.sto_ttrig, 0);
    check("s035_tdata", u_if.sto_tdata, 0);
    model_reset();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) send(i);

    // randomized rounds
    for (int r = 0; r < 10; r++) begin
      bus_wr(0, 2);
      for (int m = 0; m < TMN; m++) begin
        bus_wr(16 + 2*m, rnd_mask()); bus_wr(17 + 2*m, $urandom % 16);
      end
      for (int l = 0; l < TLN; l++) begin
        bus_wr(32 + 2*l, ($urandom & 32'h10F) | (($urandom % 4 == 0) ? 32'h200 : 32'h0));
        bus_wr(33 + 2*l, $urandom % 4);
      end
      bus_wr(1, $urandom % 6);
      bus_wr(0, 1);
      for (int c = 0; c < 300; c++) begin
        u_if.sti_tvalid = ($urandom % 4) != 0;
        u_if.sti_tdata  = ($urandom % 3 == 0) ? $urandom : ($urandom % 16);
        u_if.sto_tready = ($urandom % 4) != 0;
        if ($urandom % 16 == 0) begin
          int a;
          u_if.bus_wvalid = 1'b1;
          if ($urandom % 3 == 0) begin
            a = 0;
            u_if.bus_wdata = ($urandom % 5 == 0) ? 32'h3 : (($urandom % 3 == 0) ? 32'h2 : 32'h1);
          end else begin
            a = rnd_addr();
            u_if.bus_wdata = (a == 1 || (a >= 33 && a % 2 == 1)) ? ($urandom % 6) : ($urandom & 32'h30F);
          end
          u_if.bus_waddr = BAW'(a);
        end
        tick();
        u_if.bus_wvalid = 1'b0;
      end
      u_if.sti_tvalid = 1'b0;
      u_if.sto_tready = 1'b1;
      tick(); tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
